// File: rtl/seq_ctrl.sv
// rtl/seq_ctrl.sv - Y86 multi-cycle sequencer with memory handshake and processor status.
// Optional define Y86_SEQ_PERF_EN adds busy-cycle and retired-instruction counters.
module seq_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [3:0] icode_i,
    input  logic       instr_valid_i,
    output logic       mem_req_o,
    input  logic       mem_ack_i,
    input  logic       mem_error_i,
    output logic       fetch_en_o,
    output logic       decode_en_o,
    output logic       exec_en_o,
    output logic       mem_en_o,
    output logic       wb_en_o,
    output logic       pc_en_o,
    output logic       cc_we_o,
    output logic [2:0] stat_o,
    output logic       busy_o,
`ifdef Y86_SEQ_PERF_EN
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instr_cnt_o,
`endif
    output logic       retired_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_PCUP   = 3'd6;
    localparam logic [2:0] S_HALT   = 3'd7;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [2:0]    stat_q;
    logic [2:0]    stat_next;
    logic [CW-1:0] tmo_cnt;
    logic          waiting;
    logic          timed_out;
    logic          mem_icode;

    assign waiting   = (state == S_FETCH) || (state == S_MEM);
    // The last unacknowledged cycle ends the wait; an ack in that same cycle still wins.
    assign timed_out = waiting && !mem_ack_i && (tmo_cnt == TMO_LAST);
    assign mem_icode = (icode_i == 4'h4) || (icode_i == 4'h5) || (icode_i == 4'h8) ||
                       (icode_i == 4'h9) || (icode_i == 4'hA) || (icode_i == 4'hB);

    always_comb begin
        state_next = state;
        stat_next  = stat_q;
        case (state)
            S_IDLE: begin
                if (start_i) state_next = S_FETCH;
            end
            S_FETCH, S_MEM: begin
                if (mem_ack_i) begin
                    if (mem_error_i) begin
                        state_next = S_HALT;
                        stat_next  = STAT_ADR;
                    end else begin
                        state_next = (state == S_FETCH) ? S_DECODE : S_WB;
                    end
                end else if (timed_out) begin
                    state_next = S_HALT;
                    stat_next  = STAT_ADR;
                end
            end
            S_DECODE: begin
                if (instr_valid_i) begin
                    state_next = S_EXEC;
                end else begin
                    state_next = S_HALT;
                    stat_next  = STAT_INS;
                end
            end
            S_EXEC:  state_next = mem_icode ? S_MEM : S_WB;
            S_WB:    state_next = S_PCUP;
            S_PCUP: begin
                if (icode_i == 4'h0) begin
                    state_next = S_HALT;
                    stat_next  = STAT_HLT;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            stat_q <= STAT_AOK;
        end else begin
            state  <= state_next;
            stat_q <= stat_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt <= '0;
        end else if ((state_next != state) && ((state_next == S_FETCH) || (state_next == S_MEM))) begin
            tmo_cnt <= '0;
        end else if (waiting && !mem_ack_i) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign fetch_en_o  = (state == S_FETCH);
    assign decode_en_o = (state == S_DECODE);
    assign exec_en_o   = (state == S_EXEC);
    assign mem_en_o    = (state == S_MEM);
    assign wb_en_o     = (state == S_WB);
    assign pc_en_o     = (state == S_PCUP);
    assign mem_req_o   = waiting;
    assign cc_we_o     = (state == S_EXEC) && (icode_i == 4'h6);
    assign retired_o   = (state == S_PCUP);
    assign busy_o      = (state != S_IDLE) && (state != S_HALT);
    assign stat_o      = stat_q;

`ifdef Y86_SEQ_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_cnt_o <= '0;
            instr_cnt_o <= '0;
        end else begin
            if (busy_o)    cycle_cnt_o <= cycle_cnt_o + 32'd1;
            if (retired_o) instr_cnt_o <= instr_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_ctrl.sv
// tb/tb_seq_ctrl.sv - Directed bench for seq_ctrl checked against a per-instruction cycle-plan model.
module tb_seq_ctrl;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] icode = 4'h1;
    logic       instr_valid = 1'b1;
    logic       mem_req;
    logic       mem_ack = 1'b0;
    logic       mem_error = 1'b0;
    logic       fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en;
    logic       cc_we;
    logic [2:0] stat;
    logic       busy;
    logic       retired;
`ifdef Y86_SEQ_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
    longint      m_cyc, m_ins;
`endif

    always #5 clk = ~clk;

    seq_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .icode_i(icode),
        .instr_valid_i(instr_valid), .mem_req_o(mem_req), .mem_ack_i(mem_ack),
        .mem_error_i(mem_error), .fetch_en_o(fetch_en), .decode_en_o(decode_en),
        .exec_en_o(exec_en), .mem_en_o(mem_en), .wb_en_o(wb_en), .pc_en_o(pc_en),
        .cc_we_o(cc_we), .stat_o(stat), .busy_o(busy),
`ifdef Y86_SEQ_PERF_EN
        .cycle_cnt_o(cycle_cnt), .instr_cnt_o(instr_cnt),
`endif
        .retired_o(retired)
    );

    // One entry per clock: inputs driven for the cycle and the outputs the spec demands in it.
    typedef struct packed {
        logic [5:0] en;
        logic       req, cc, busy, ret;
        logic [2:0] stat;
        logic [3:0] icode;
        logic       ack, err, valid, start, rst, chk;
    } cyc_t;

    cyc_t plan[$];
    cyc_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc_no = 0;
    logic [2:0] m_stat = 3'd1;
    logic [3:0] m_icode = 4'h1;

    task automatic push(input logic [5:0] en, input logic req, input logic cc, input logic ret,
                        input logic ack, input logic err, input logic valid,
                        input logic st, input logic rs, input logic chk);
        cyc_t e;
        e.en = en; e.req = req; e.cc = cc; e.ret = ret;
        e.busy = |en;
        e.stat = m_stat; e.icode = m_icode;
        e.ack = ack; e.err = err; e.valid = valid; e.start = st; e.rst = rs; e.chk = chk;
        plan.push_back(e);
    endtask

    task automatic do_reset();
        push(6'b0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        m_stat = 3'd1;
        push(6'b0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    endtask

    task automatic do_start();
        push(6'b0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) push(6'b0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    endtask

    // mode 0: ack after w waits, 1: ack with error after w waits, 2: never ack (timeout)
    task automatic mem_phase(input logic [5:0] en, input int w, input int mode, output bit ok);
        if (mode == 2) begin
            for (int i = 0; i < TMO; i++) push(en, 1, 0, 0, 0, 0, 1, 0, 0, 1);
            m_stat = 3'd3;
            ok = 0;
        end else begin
            for (int i = 0; i <= w; i++)
                push(en, 1, 0, 0, i == w, (i == w) && (mode == 1), 1, 0, 0, 1);
            ok = (mode == 0);
            if (!ok) m_stat = 3'd3;
        end
    endtask

    task automatic instr(input logic [3:0] ic, input int wf, input int fmode, input logic valid,
                         input int wm, input int mmode, input bit rst_exec);
        bit ok;
        m_icode = ic;
        mem_phase(6'b100000, wf, fmode, ok);
        if (!ok) return;
        push(6'b010000, 0, 0, 0, 0, 0, valid, 0, 0, 1);
        if (!valid) begin
            m_stat = 3'd4;
            return;
        end
        push(6'b001000, 0, ic == 4'h6, 0, 0, 0, 1, 0, rst_exec, 1);
        if (rst_exec) begin
            push(6'b0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
            return;
        end
        if (ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
            mem_phase(6'b000100, wm, mmode, ok);
            if (!ok) return;
        end
        push(6'b000010, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        push(6'b000001, 0, 0, 1, 0, 0, 1, 0, 0, 1);
        if (ic == 4'h0) m_stat = 3'd2;
    endtask

    task automatic pin_len(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL plan_len_%s got=%0d want=%0d", name, got, want);
    endtask

    task automatic run_plan();
        foreach (plan[i]) begin
            @(posedge clk);
            #1;
            rst = plan[i].rst; start = plan[i].start; icode = plan[i].icode;
            instr_valid = plan[i].valid; mem_ack = plan[i].ack; mem_error = plan[i].err;
            exp_q.push_back(plan[i]);
        end
        plan.delete();
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cyc_t e;
            logic [5:0] en_got;
            bit ok;
            e = exp_q.pop_front();
            cyc_no++;
            en_got = {fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en};
            if (e.chk) begin
                ok = (en_got === e.en) && (mem_req === e.req) && (cc_we === e.cc) &&
                     (busy === e.busy) && (retired === e.ret) && (stat === e.stat);
`ifdef Y86_SEQ_PERF_EN
                ok = ok && (cycle_cnt === 32'(m_cyc)) && (instr_cnt === 32'(m_ins));
`endif
                n_checks++;
                if (ok) n_pass++;
                else $display("FAIL cycle_%0d got en=%b req=%b cc=%b busy=%b ret=%b stat=%0d want en=%b req=%b cc=%b busy=%b ret=%b stat=%0d",
                              cyc_no, en_got, mem_req, cc_we, busy, retired, stat,
                              e.en, e.req, e.cc, e.busy, e.ret, e.stat);
            end
`ifdef Y86_SEQ_PERF_EN
            if (e.rst) begin
                m_cyc = 0; m_ins = 0;
            end else begin
                m_cyc += e.busy; m_ins += e.ret;
            end
`endif
        end
    end

    initial begin
        int s;
        // Run 1: nop, OPq, rrmovq, pushq with late ack, mrmovq, ack on timeout cycle, halt
        do_reset();
        do_start();
        s = plan.size(); instr(4'h1, 0, 0, 1, 0, 0, 0); pin_len("nop", plan.size() - s, 5);
        s = plan.size(); instr(4'h6, 0, 0, 1, 0, 0, 0); pin_len("opq", plan.size() - s, 5);
        instr(4'h2, 0, 0, 1, 0, 0, 0);
        s = plan.size(); instr(4'hA, 0, 0, 1, 3, 0, 0); pin_len("pushq_wait3", plan.size() - s, 9);
        s = plan.size(); instr(4'h5, 0, 0, 1, 0, 0, 0); pin_len("mrmovq", plan.size() - s, 6);
        s = plan.size(); instr(4'h1, TMO - 1, 0, 1, 0, 0, 0); pin_len("ack_at_tmo", plan.size() - s, 8);
        instr(4'h0, 0, 0, 1, 0, 0, 0);
        halt_cycles(3);
        run_plan();

        // Run 2: fetch timeout
        do_reset();
        do_start();
        s = plan.size(); instr(4'h1, 0, 2, 1, 0, 0, 0); pin_len("fetch_tmo", plan.size() - s, TMO);
        halt_cycles(2);
        run_plan();

        // Run 3: address error on MEM ack after one wait
        do_reset();
        do_start();
        instr(4'h4, 0, 0, 1, 1, 1, 0);
        halt_cycles(2);
        run_plan();

        // Run 4: address error on FETCH ack
        do_reset();
        do_start();
        instr(4'h1, 2, 1, 1, 0, 0, 0);
        halt_cycles(2);
        run_plan();

        // Run 5: illegal instruction
        do_reset();
        do_start();
        instr(4'h3, 0, 0, 0, 0, 0, 0);
        halt_cycles(2);
        run_plan();

        // Run 6: reset during EXEC, then recover
        do_reset();
        do_start();
        instr(4'h6, 0, 0, 1, 0, 0, 1);
        do_start();
        instr(4'h1, 0, 0, 1, 0, 0, 0);
        run_plan();

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
